procb_rd_ctrl: RTL

PROCB_RD_CTRL -- requirements
Module: procb_rd_ctrl

---
 rtl/procb_rd_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/procb_rd_ctrl.sv
// Read controller for procb_buf: round-robin thread selection, FWFT record streaming
// to a valid/ready consumer, and per-pass completion signalling.
`ifndef PROCB_D_WIDTH
`define PROCB_D_WIDTH 16
`endif
`ifndef MSB
`define MSB(x) (((x) > 0) ? ($clog2((x) + 1) - 1) : 0)
`endif

module procb_rd_ctrl #(
  parameter int N_THREADS     = 6,
  parameter int N_THREADS_MSB = `MSB(N_THREADS-1),
  parameter int D_WIDTH       = `PROCB_D_WIDTH
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [N_THREADS-1:0]     thread_ready,
  output logic [N_THREADS_MSB:0]   buf_rd_thread_num,
  output logic                     buf_rd_en,
  output logic                     buf_rd_rst,
  output logic                     buf_lookup_en,
  input  logic [D_WIDTH-1:0]       buf_dout,
  input  logic                     buf_aempty,
  input  logic                     buf_empty,
  output logic [D_WIDTH-1:0]       out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_THREADS_MSB:0]   out_thread_num,
  output logic                     out_last,
  output logic                     done,
  output logic [N_THREADS_MSB:0]   done_thread_num,
  output logic                     err
);

  localparam int TW = N_THREADS_MSB + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] sel_q, sel_d;
  logic [TW-1:0] last_q, last_d;
  logic          gap_q, gap_d;
  logic          err_q, err_d;

  logic [TW-1:0] cand_s;
  logic          hit_s;
  logic          pick_vld_s;
  logic [TW-1:0] pick_idx_s;
  logic          valid_s;
  logic          last_s;
  logic          accept_s;
  logic          chk_empty_s;

  // Round-robin search starting one past the last served thread.
  always_comb begin
    pick_vld_s = 1'b0;
    pick_idx_s = '0;
    cand_s     = '0;
    hit_s      = 1'b0;
    for (int k = 1; k <= N_THREADS; k++) begin
      cand_s     = TW'((int'(last_q) + k) % N_THREADS);
      hit_s      = !pick_vld_s && thread_ready[cand_s];
      pick_idx_s = hit_s ? cand_s : pick_idx_s;
      pick_vld_s = pick_vld_s | hit_s;
    end
  end

  assign valid_s     = (state_q == S_STREAM) && !gap_q;
  assign last_s      = buf_dout[D_WIDTH-1] | buf_aempty;
  assign accept_s    = valid_s & out_ready;
  assign chk_empty_s = (state_q == S_CHECK) && buf_empty;

  // Next-state logic; gap_q inserts the one-cycle pointer-settle bubble after a non-final read.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    gap_d   = gap_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld_s) begin
          sel_d   = pick_idx_s;
          state_d = S_SETTLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETTLE: state_d = S_CHECK;
      S_CHECK: begin
        if (buf_empty) begin
          err_d   = 1'b1;
          last_d  = sel_q;
          state_d = S_IDLE;
        end else begin
          gap_d   = 1'b0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (out_ready) begin
          if (last_s) begin
            state_d = S_FINISH;
          end else begin
            gap_d = 1'b1;
          end
        end else begin
          state_d = S_STREAM;
        end
      end
      S_FINISH: begin
        last_d  = sel_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any pass in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      last_q  <= TW'(N_THREADS - 1);
      gap_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end
  end

  assign buf_rd_thread_num = sel_q;
  assign buf_lookup_en     = 1'b0;
  assign buf_rd_en         = accept_s | chk_empty_s;
  assign buf_rd_rst        = (accept_s & last_s) | chk_empty_s;
  assign out_valid         = valid_s;
  assign out_data          = valid_s ? buf_dout : '0;
  assign out_thread_num    = valid_s ? sel_q : '0;
  assign out_last          = valid_s & last_s;
  assign done              = chk_empty_s | (state_q == S_FINISH);
  assign done_thread_num   = done ? sel_q : '0;
  assign err               = err_q;

endmodule
